// File: rtl/game_sequencer_if.sv
// game_sequencer_if: frame/jump handshakes and game status shared by the sequencer, CPU and display.
// SCORE_EN adds the score bus.
interface game_sequencer_if #(parameter int OVR_W = 8);
  logic frame_tick, button_press, pause_switch, collision_detected, frame_ack, jump_ack;
  logic screen_ready, jump_req, game_over, paused;
  logic [1:0] lives;
  logic [2:0] state;
  logic [OVR_W-1:0] frame_overrun;
`ifdef SCORE_EN
  logic [15:0] score;
  modport master(
    output frame_tick, button_press, pause_switch, collision_detected, frame_ack, jump_ack,
    input screen_ready, jump_req, game_over, paused, lives, state, frame_overrun, score
  );
  modport slave(
    input frame_tick, button_press, pause_switch, collision_detected, frame_ack, jump_ack,
    output screen_ready, jump_req, game_over, paused, lives, state, frame_overrun, score
  );
`else
  modport master(
    output frame_tick, button_press, pause_switch, collision_detected, frame_ack, jump_ack,
    input screen_ready, jump_req, game_over, paused, lives, state, frame_overrun
  );
  modport slave(
    input frame_tick, button_press, pause_switch, collision_detected, frame_ack, jump_ack,
    output screen_ready, jump_req, game_over, paused, lives, state, frame_overrun
  );
`endif
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: frame handshake, jump latch, lives and IDLE/RUN/HIT/PAUSE/OVER game state.
// Optional SCORE_EN adds a saturating 16-bit frame score.
module game_sequencer #(
  parameter int START_LIVES = 3,
  parameter int HIT_FRAMES = 6,
  parameter int OVR_W = 8
) (
  input logic clk,
  input logic reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, HIT = 3'd2, PAUSE = 3'd3, OVER = 3'd4} state_t;
  state_t state_q, state_d, ret_q, ret_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] hit_q, hit_d;
  logic sr_q, sr_d, jr_q, jr_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic [2:0] btn_q, btn_d;
  logic [1:0] pse_q, pse_d;
  logic btn_rise, pause_s, active, tick;
  // btn_q = {previous synced, synced, first stage}
  assign btn_rise = btn_q[1] & ~btn_q[2];
  assign pause_s = pse_q[1];
  assign active = (state_q == RUN) || (state_q == HIT);
  assign tick = active & bus.frame_tick;
  always_comb begin
    btn_d = {btn_q[1:0], bus.button_press};
    pse_d = {pse_q[0], bus.pause_switch};
    state_d = state_q;
    ret_d = ret_q;
    lives_d = lives_q;
    hit_d = hit_q;
    case (state_q)
      IDLE: state_d = btn_rise ? RUN : IDLE;
      RUN: begin
        if (bus.collision_detected) begin
          lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
          state_d = (lives_q <= 2'd1) ? OVER : HIT;
          hit_d = HIT_FRAMES[7:0];
        end else if (pause_s) begin
          state_d = PAUSE;
          ret_d = RUN;
        end
      end
      HIT: begin
        if (pause_s) begin
          state_d = PAUSE;
          ret_d = HIT;
        end else if (bus.frame_tick) begin
          hit_d = hit_q - 8'd1;
          state_d = (hit_q == 8'd1) ? RUN : HIT;
        end
      end
      PAUSE: state_d = pause_s ? PAUSE : ret_q;
      OVER: begin
        if (btn_rise) begin
          state_d = IDLE;
          lives_d = START_LIVES[1:0];
        end
      end
      default: state_d = IDLE;
    endcase
    // a new frame beats a simultaneous ack; IDLE/OVER never present a frame
    sr_d = (state_d == IDLE || state_d == OVER) ? 1'b0 : tick ? 1'b1 : bus.frame_ack ? 1'b0 : sr_q;
    ovr_d = (tick && sr_q && !bus.frame_ack && ovr_q != '1) ? ovr_q + 1'b1 : ovr_q;
    jr_d = (active && btn_rise) ? 1'b1 : bus.jump_ack ? 1'b0 : jr_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ret_q <= RUN;
      lives_q <= START_LIVES[1:0];
      hit_q <= '0;
      sr_q <= 1'b0;
      jr_q <= 1'b0;
      ovr_q <= '0;
      btn_q <= '0;
      pse_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      lives_q <= lives_d;
      hit_q <= hit_d;
      sr_q <= sr_d;
      jr_q <= jr_d;
      ovr_q <= ovr_d;
      btn_q <= btn_d;
      pse_q <= pse_d;
    end
  end
`ifdef SCORE_EN
  logic [15:0] score_q, score_d;
  always_comb begin
    score_d = (state_q == IDLE && state_d == RUN) ? 16'd0 :
              (tick && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) score_q <= '0;
    else score_q <= score_d;
  end
  assign bus.score = score_q;
`endif
  assign bus.state = state_q;
  assign bus.lives = lives_q;
  assign bus.screen_ready = sr_q;
  assign bus.jump_req = jr_q;
  assign bus.frame_overrun = ovr_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.paused = (state_q == PAUSE);
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: vector table, directed corner sequences and random stimulus checked
// against a frame-level model of the game rules.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  game_sequencer_if #(.OVR_W(8)) bus();
  game_sequencer #(.START_LIVES(3), .HIT_FRAMES(6), .OVR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic btn, pau, col, tck, fak, jak;
    logic [2:0] st;
    logic [1:0] lv;
    logic sr, jr;
    logic [7:0] ov;
  } vec_t;
  vec_t tbl[17];

  int ms, ml, mh, mr, msr, mjr, movr, msc;
  bit mb1, mb2, mbp, mp1, mp2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; ml = 3; mh = 0; mr = 1; msr = 0; mjr = 0; movr = 0; msc = 0;
    mb1 = 0; mb2 = 0; mbp = 0; mp1 = 0; mp2 = 0;
  endtask

  task automatic model_edge();
    bit rise, act, tk;
    int ns, nl, nh, nr;
    rise = mb2 && !mbp;
    act = (ms == 1 || ms == 2);
    tk = act && bus.frame_tick;
    ns = ms; nl = ml; nh = mh; nr = mr;
    case (ms)
      0: if (rise) ns = 1;
      1: begin
        if (bus.collision_detected) begin
          nl = ml - 1;
          ns = (nl == 0) ? 4 : 2;
          nh = 6;
        end else if (mp2) begin
          ns = 3; nr = 1;
        end
      end
      2: begin
        if (mp2) begin
          ns = 3; nr = 2;
        end else if (bus.frame_tick) begin
          nh = mh - 1;
          if (nh == 0) ns = 1;
        end
      end
      3: if (!mp2) ns = mr;
      default: if (rise) begin ns = 0; nl = 3; end
    endcase
    if (tk && msr == 1 && !bus.frame_ack && movr < 255) movr++;
    if (ns == 0 || ns == 4) msr = 0;
    else if (tk) msr = 1;
    else if (bus.frame_ack) msr = 0;
    if (act && rise) mjr = 1;
    else if (bus.jump_ack) mjr = 0;
    if (ms == 0 && ns == 1) msc = 0;
    else if (tk && msc < 65535) msc++;
    ms = ns; ml = nl; mh = nh; mr = nr;
    mbp = mb2; mb2 = mb1; mb1 = bus.button_press;
    mp2 = mp1; mp1 = bus.pause_switch;
  endtask

  task automatic chk_model();
    chk("model", {bus.state, bus.lives, bus.screen_ready, bus.jump_req, bus.game_over, bus.paused, bus.frame_overrun},
        {3'(ms), 2'(ml), 1'(msr), 1'(mjr), 1'(ms == 4), 1'(ms == 3), 8'(movr)});
`ifdef SCORE_EN
    chk("score", bus.score, 16'(msc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic tick_pulse();
    bus.frame_tick = 1; step();
    bus.frame_tick = 0; step();
  endtask

  task automatic hit_and_recover();
    bus.collision_detected = 1; step();
    bus.collision_detected = 0;
    repeat (6) tick_pulse();
  endtask

  initial begin
    bus.frame_tick = 0; bus.button_press = 0; bus.pause_switch = 0;
    bus.collision_detected = 0; bus.frame_ack = 0; bus.jump_ack = 0;
    //          btn pau col tck fak jak  st  lv sr jr ov
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 8'd0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 3'd0, 2'd3, 0, 0, 8'd0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 3'd1, 2'd3, 0, 0, 8'd0};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 3'd1, 2'd3, 1, 0, 8'd0};
    tbl[4]  = '{1, 0, 0, 0, 1, 0, 3'd1, 2'd3, 0, 0, 8'd0};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, 3'd1, 2'd3, 1, 0, 8'd0};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 3'd1, 2'd3, 1, 0, 8'd1};
    tbl[7]  = '{1, 0, 0, 1, 1, 0, 3'd1, 2'd3, 1, 0, 8'd1};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 3'd1, 2'd3, 0, 0, 8'd1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 3'd1, 2'd3, 0, 0, 8'd1};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 3'd1, 2'd3, 0, 0, 8'd1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 3'd1, 2'd3, 0, 0, 8'd1};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 3'd1, 2'd3, 0, 1, 8'd1};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 3'd1, 2'd3, 0, 0, 8'd1};
    tbl[14] = '{1, 0, 1, 0, 0, 0, 3'd2, 2'd2, 0, 0, 8'd1};
    tbl[15] = '{1, 0, 1, 1, 0, 0, 3'd2, 2'd2, 1, 0, 8'd1};
    tbl[16] = '{1, 0, 0, 0, 1, 0, 3'd2, 2'd2, 0, 0, 8'd1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.state, bus.lives, bus.screen_ready, bus.jump_req, bus.frame_overrun}, {3'd0, 2'd3, 1'b0, 1'b0, 8'd0});
    reset = 1;
    for (int i = 0; i < 17; i++) begin
      bus.button_press = tbl[i].btn; bus.pause_switch = tbl[i].pau;
      bus.collision_detected = tbl[i].col; bus.frame_tick = tbl[i].tck;
      bus.frame_ack = tbl[i].fak; bus.jump_ack = tbl[i].jak;
      step();
      chk($sformatf("vec%0d", i), {bus.state, bus.lives, bus.screen_ready, bus.jump_req, bus.frame_overrun},
          {tbl[i].st, tbl[i].lv, tbl[i].sr, tbl[i].jr, tbl[i].ov});
    end
    bus.button_press = 0; bus.frame_ack = 0;
    // invulnerability with collision held, dropped on the final tick
    bus.collision_detected = 1;
    repeat (4) tick_pulse();
    chk("hit_hold", {bus.state, bus.lives}, {3'd2, 2'd2});
    bus.collision_detected = 0; bus.frame_tick = 1; step(); bus.frame_tick = 0;
    chk("hit_end", {bus.state, bus.lives}, {3'd1, 2'd2});
    bus.collision_detected = 1; step(); bus.collision_detected = 0;
    chk("second_hit", {bus.state, bus.lives}, {3'd2, 2'd1});
    // pause with hit counter at 4
    repeat (2) tick_pulse();
    bus.pause_switch = 1; repeat (3) step();
    chk("pause_enter", {bus.state, bus.paused}, {3'd3, 1'b1});
    bus.collision_detected = 1;
    repeat (10) tick_pulse();
    bus.collision_detected = 0;
    chk("pause_hold", {bus.state, bus.lives, bus.paused}, {3'd3, 2'd1, 1'b1});
    bus.pause_switch = 0; repeat (3) step();
    chk("pause_exit", {bus.state, bus.paused}, {3'd2, 1'b0});
    repeat (3) tick_pulse();
    chk("hit_resume", bus.state, 3'd2);
    tick_pulse();
    chk("hit_done", bus.state, 3'd1);
    // last life lost
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    bus.collision_detected = 1; step(); bus.collision_detected = 0;
    chk("over", {bus.state, bus.lives, bus.game_over, bus.screen_ready}, {3'd4, 2'd0, 1'b1, 1'b0});
    bus.button_press = 1; repeat (3) step();
    chk("restart", {bus.state, bus.lives, bus.game_over}, {3'd0, 2'd3, 1'b0});
    bus.button_press = 0; step();
    // overrun saturation
    bus.button_press = 1; repeat (3) step();
    bus.button_press = 0; step();
    chk("start", bus.state, 3'd1);
    bus.frame_tick = 1; repeat (302) step(); bus.frame_tick = 0; step();
    chk("ovr_sat", bus.frame_overrun, 8'd255);
    // asynchronous reset mid-RUN with one life left
    hit_and_recover();
    hit_and_recover();
    chk("pre_reset", {bus.state, bus.lives}, {3'd1, 2'd1});
    bus.frame_tick = 1; step(); bus.frame_tick = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("async_reset", {bus.state, bus.lives, bus.screen_ready, bus.jump_req, bus.game_over, bus.paused, bus.frame_overrun},
        {3'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1;
    // random play
    for (int i = 0; i < 3000; i++) begin
      bus.frame_tick = ($urandom_range(3) == 0);
      bus.frame_ack = ($urandom_range(2) == 0);
      bus.jump_ack = ($urandom_range(3) == 0);
      bus.collision_detected = ($urandom_range(19) == 0);
      if ($urandom_range(7) == 0) bus.button_press = ~bus.button_press;
      if ($urandom_range(39) == 0) bus.pause_switch = ~bus.pause_switch;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
